// File: rtl/libv_deque.sv
// rtl/libv_deque.sv - parametrised double-ended queue, circular register array with head/tail pointers
// Optional sticky error flag and port enabled by defining LIBV_DEQUE_ERR_EN.
module libv_deque #(
    parameter int W = 32,
    parameter int N = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       front_push,
    input  logic                       front_pop,
    input  logic [W-1:0]               front_push_dat,
    output logic [W-1:0]               front_dat,
    input  logic                       back_push,
    input  logic                       back_pop,
    input  logic [W-1:0]               back_push_dat,
    output logic [W-1:0]               back_dat,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(N+1)-1:0]     cnt
`ifdef LIBV_DEQUE_ERR_EN
    ,
    output logic                       err
`endif
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(N+1);
    localparam logic [PW-1:0] LAST = PW'(N-1);
    localparam logic [CW-1:0] CAP  = CW'(N);

    logic [W-1:0]  mem_q [N];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, head_m1, tail_m1;
    logic [CW-1:0] cnt_q, cnt_d;

    logic f_push_req, f_pop_req, b_push_req, b_pop_req;
    logic fpush_ok, fpop_ok, bpush_ok, bpop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? LAST : p - PW'(1);
    endfunction

    always_comb begin
        // Push and pop on the same end cancel each other out entirely.
        f_push_req = front_push & ~front_pop;
        f_pop_req  = front_pop  & ~front_push;
        b_push_req = back_push  & ~back_pop;
        b_pop_req  = back_pop   & ~back_push;

        fpush_ok = f_push_req && (cnt_q < CAP);
        fpop_ok  = f_pop_req  && (cnt_q != '0);
        bpush_ok = b_push_req && ((cnt_q + CW'(fpush_ok)) < CAP);
        bpop_ok  = b_pop_req  && (cnt_q > CW'(fpop_ok));

        head_m1 = ptr_dec(head_q);
        tail_m1 = ptr_dec(tail_q);

        head_d = head_q;
        if (fpush_ok)
            head_d = head_m1;
        else if (fpop_ok)
            head_d = ptr_inc(head_q);

        tail_d = tail_q;
        if (bpush_ok)
            tail_d = ptr_inc(tail_q);
        else if (bpop_ok)
            tail_d = tail_m1;

        cnt_d = cnt_q + CW'(fpush_ok) + CW'(bpush_ok) - CW'(fpop_ok) - CW'(bpop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Both pushes accepted together implies cnt <= N-2, so the two slots never collide.
    always_ff @(posedge clk) begin
        if (rst_n && fpush_ok)
            mem_q[head_m1] <= front_push_dat;
        if (rst_n && bpush_ok)
            mem_q[tail_q] <= back_push_dat;
    end

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CAP);
    assign cnt       = cnt_q;
    assign front_dat = empty ? '0 : mem_q[head_q];
    assign back_dat  = empty ? '0 : mem_q[tail_m1];

`ifdef LIBV_DEQUE_ERR_EN
    logic err_q, err_evt;

    assign err_evt = (front_push & front_pop) | (back_push & back_pop)
                   | (f_push_req & ~fpush_ok) | (f_pop_req & ~fpop_ok)
                   | (b_push_req & ~bpush_ok) | (b_pop_req & ~bpop_ok);

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (err_evt)
            err_q <= 1'b1;
    end

    assign err = err_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && err_evt)
            $error("libv_deque: overflow, underflow or same-end push+pop");
    end
`endif
`endif

endmodule

// File: tb/tb_libv_deque.sv
// tb/tb_libv_deque.sv - randomized and directed bench for libv_deque against a queue-based model
module tb_libv_deque;

    localparam int W  = 16;
    localparam int N  = 5;
    localparam int CW = $clog2(N+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          front_push = 1'b0, front_pop = 1'b0;
    logic          back_push = 1'b0, back_pop = 1'b0;
    logic [W-1:0]  front_push_dat = '0, back_push_dat = '0;
    logic [W-1:0]  front_dat, back_dat;
    logic          empty, full;
    logic [CW-1:0] cnt;
`ifdef LIBV_DEQUE_ERR_EN
    logic          err;
`endif

    libv_deque #(.W(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .front_push(front_push), .front_pop(front_pop),
        .front_push_dat(front_push_dat), .front_dat(front_dat),
        .back_push(back_push), .back_pop(back_pop),
        .back_push_dat(back_push_dat), .back_dat(back_dat),
        .empty(empty), .full(full), .cnt(cnt)
`ifdef LIBV_DEQUE_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    logic [W-1:0] q[$];
    bit           merr = 1'b0;
    bit           model_on = 1'b0;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of requests and advance the reference model by the deque rules.
    task automatic step(input bit r, input bit fp, input bit fpo, input logic [W-1:0] fd,
                        input bit bp, input bit bpo, input logic [W-1:0] bd);
        int c;
        bit fpu_ok, fpo_ok, bpu_ok, bpo_ok;
        rst_n = ~r;
        front_push = fp; front_pop = fpo; front_push_dat = fd;
        back_push = bp;  back_pop = bpo;  back_push_dat = bd;
        @(posedge clk);
        if (r) begin
            q.delete();
            merr = 1'b0;
        end else begin
            c = q.size();
            fpu_ok = fp && !fpo && (c < N);
            fpo_ok = fpo && !fp && (c > 0);
            bpu_ok = bp && !bpo && (c + int'(fpu_ok) < N);
            bpo_ok = bpo && !bp && (c - int'(fpo_ok) > 0);
            if (fpo_ok) void'(q.pop_front());
            if (bpo_ok) void'(q.pop_back());
            if (fpu_ok) q.push_front(fd);
            if (bpu_ok) q.push_back(bd);
            if ((fp && fpo) || (bp && bpo) || (fp && !fpo && !fpu_ok) || (fpo && !fp && !fpo_ok)
                || (bp && !bpo && !bpu_ok) || (bpo && !bp && !bpo_ok))
                merr = 1'b1;
        end
        #1;
        rst_n = 1'b1;
        front_push = 1'b0; front_pop = 1'b0; back_push = 1'b0; back_pop = 1'b0;
    endtask

    task automatic do_rst();                  step(1, 0, 0, '0, 0, 0, '0); endtask
    task automatic idle();                    step(0, 0, 0, '0, 0, 0, '0); endtask
    task automatic push_b(input logic [W-1:0] d); step(0, 0, 0, '0, 1, 0, d); endtask
    task automatic push_f(input logic [W-1:0] d); step(0, 1, 0, d, 0, 0, '0); endtask
    task automatic pop_f();                   step(0, 0, 1, '0, 0, 0, '0); endtask
    task automatic pop_b();                   step(0, 0, 0, '0, 0, 1, '0); endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("cnt", 64'(cnt), 64'(q.size()));
            chk("empty", 64'(empty), 64'(q.size() == 0));
            chk("full", 64'(full), 64'(q.size() == N));
            chk("front_dat", 64'(front_dat), (q.size() != 0) ? 64'(q[0]) : 64'd0);
            chk("back_dat", 64'(back_dat), (q.size() != 0) ? 64'(q[$]) : 64'd0);
`ifdef LIBV_DEQUE_ERR_EN
            chk("err", 64'(err), 64'(merr));
`endif
        end
    end

    initial begin
        int pp;
        bit r, fp, fpo, bp, bpo;

        do_rst();
        do_rst();
        model_on = 1'b1;
        chk("rst_cnt", 64'(cnt), 0);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_full", 64'(full), 0);
        chk("rst_front", 64'(front_dat), 0);
        chk("rst_back", 64'(back_dat), 0);
        repeat (3) idle();
        chk("idle_empty", 64'(empty), 1);

        for (int i = 1; i <= N; i++) push_b(W'(i));
        chk("bo_full", 64'(full), 1);
        chk("bo_cnt", 64'(cnt), 5);
        for (int i = 1; i <= N; i++) begin
            chk("bo_front", 64'(front_dat), 64'(i));
            pop_f();
        end
        chk("bo_empty", 64'(empty), 1);

        push_f(16'hA); push_f(16'hB); push_f(16'hC);
        chk("fo_front", 64'(front_dat), 64'hC);
        chk("fo_back", 64'(back_dat), 64'hA);
        chk("fo_pop0", 64'(back_dat), 64'hA); pop_b();
        chk("fo_pop1", 64'(back_dat), 64'hB); pop_b();
        chk("fo_pop2", 64'(back_dat), 64'hC); pop_b();
        chk("fo_empty", 64'(empty), 1);

        for (int i = 0; i < 12; i++) begin
            push_b(W'(16'h100 + i));
            chk("wrap_dat", 64'(front_dat), 64'(16'h100 + i));
            chk("wrap_cnt", 64'(cnt), 1);
            pop_f();
        end

        push_b(16'h11);
        step(0, 0, 1, '0, 0, 1, '0);
        chk("pp_cnt", 64'(cnt), 0);

        for (int i = 0; i < N-1; i++) push_b(W'(16'h30 + i));
        step(0, 1, 0, 16'h21, 1, 0, 16'h22);
        chk("ff_cnt", 64'(cnt), 5);
        chk("ff_full", 64'(full), 1);
        chk("ff_front", 64'(front_dat), 64'h21);
        chk("ff_back", 64'(back_dat), 64'h33);
        push_b(16'h44);
        chk("ovf_cnt", 64'(cnt), 5);
        chk("ovf_back", 64'(back_dat), 64'h33);

        do_rst();
        pop_f();
        chk("udf_cnt", 64'(cnt), 0);
        push_b(16'h1); push_b(16'h2); push_b(16'h3);
        step(0, 1, 0, 16'h77, 0, 1, '0);
        chk("xb_cnt", 64'(cnt), 3);
        chk("xb_front", 64'(front_dat), 64'h77);
        chk("xb_back", 64'(back_dat), 64'h2);
        step(0, 1, 1, 16'h99, 0, 0, '0);
        chk("same_cnt", 64'(cnt), 3);
        chk("same_front", 64'(front_dat), 64'h77);
        step(1, 1, 0, 16'h55, 1, 0, 16'h66);
        chk("rstwin_cnt", 64'(cnt), 0);

        pp = 60;
        for (int i = 0; i < 4000; i++) begin
            if (i % 150 == 0) pp = (pp == 60) ? 30 : 60;
            r   = ($urandom_range(0, 199) == 0);
            fp  = ($urandom_range(0, 99) < pp);
            bp  = ($urandom_range(0, 99) < pp);
            fpo = ($urandom_range(0, 99) < 90 - pp);
            bpo = ($urandom_range(0, 99) < 90 - pp);
            step(r, fp, fpo, W'($urandom), bp, bpo, W'($urandom));
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
